// File: rtl/cve2_wb_pkg.sv
// Shared types and helpers for the writeback arbiter and its load queue.
package cve2_wb_pkg;

  // Widest load data the entry struct can carry; narrower cores zero-extend.
  localparam int unsigned WbMaxDataWidth = 64;

  typedef struct packed {
    logic                      valid;
    logic [4:0]                rd;
    logic [WbMaxDataWidth-1:0] data;
    logic                      filled;
  } wb_entry_t;

  // Architectural register address width: 16 registers for RV32E, else 32.
  function automatic int unsigned reg_addr_width(bit rv32e);
    return rv32e ? 4 : 5;
  endfunction

endpackage

// File: rtl/cve2_wb_arbiter_if.sv
// Bundle of execute, LSU, decode and register-file signals around the arbiter.
interface cve2_wb_arbiter_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 ex_we_i;
  logic [4:0]           ex_waddr_i;
  logic [DataWidth-1:0] ex_wdata_i;
  logic                 lsu_issue_i;
  logic [4:0]           lsu_issue_rd_i;
  logic                 lsu_issue_ready_o;
  logic                 lsu_rvalid_i;
  logic [DataWidth-1:0] lsu_rdata_i;
  logic                 id_valid_i;
  logic [4:0]           id_raddr_a_i;
  logic [4:0]           id_raddr_b_i;
  logic [4:0]           id_waddr_i;
  logic                 id_stall_o;
  logic                 rf_we_o;
  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic                 err_o;

  modport slave (
    input  ex_we_i, ex_waddr_i, ex_wdata_i,
    input  lsu_issue_i, lsu_issue_rd_i, lsu_rvalid_i, lsu_rdata_i,
    input  id_valid_i, id_raddr_a_i, id_raddr_b_i, id_waddr_i,
    output lsu_issue_ready_o, id_stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, err_o
  );

  modport master (
    output ex_we_i, ex_waddr_i, ex_wdata_i,
    output lsu_issue_i, lsu_issue_rd_i, lsu_rvalid_i, lsu_rdata_i,
    output id_valid_i, id_raddr_a_i, id_raddr_b_i, id_waddr_i,
    input  lsu_issue_ready_o, id_stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, err_o
  );
endinterface

// File: rtl/cve2_wb_load_queue.sv
// Circular queue of outstanding loads: allocate on issue, fill in order on
// response, pop at head on drain. Also produces the pending-destination mask.
module cve2_wb_load_queue
  import cve2_wb_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2,
  parameter int unsigned NumRegs   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_issue,
  input  logic [4:0]           i_issue_rd,
  output logic                 o_ready,
  input  logic                 i_rvalid,
  input  logic [DataWidth-1:0] i_rdata,
  input  logic                 i_pop,
  output logic                 o_head_ready,
  output logic [4:0]           o_head_rd,
  output logic [DataWidth-1:0] o_head_data,
  output logic [NumRegs-1:0]   o_pending,
  output logic                 o_resp_err
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  wb_entry_t        r_q [Depth];
  logic [PtrW-1:0]  r_head, r_tail, r_fill;
  logic [CntW-1:0]  r_count, r_unfilled;
  logic             w_push, w_fill, w_pop;
  logic [NumRegs-1:0] w_pending;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_ready      = (r_count < CntW'(Depth));
  assign w_push       = i_issue & o_ready;
  assign w_fill       = i_rvalid & (r_unfilled != '0);
  assign o_resp_err   = i_rvalid & (r_unfilled == '0);
  assign o_head_ready = r_q[r_head].valid & r_q[r_head].filled;
  assign w_pop        = i_pop & o_head_ready;
  assign o_head_rd    = r_q[r_head].rd;
  assign o_head_data  = r_q[r_head].data[DataWidth-1:0];
  assign o_pending    = w_pending;

  // Entry storage and pointers; push/fill/pop always target distinct slots.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < Depth; i++) r_q[i] <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
    end else begin
      if (w_push) begin
        r_q[r_tail].valid  <= 1'b1;
        r_q[r_tail].rd     <= i_issue_rd;
        r_q[r_tail].data   <= '0;
        r_q[r_tail].filled <= 1'b0;
        r_tail             <= ptr_inc(r_tail);
      end
      if (w_fill) begin
        r_q[r_fill].data   <= WbMaxDataWidth'(i_rdata);
        r_q[r_fill].filled <= 1'b1;
        r_fill             <= ptr_inc(r_fill);
      end
      if (w_pop) begin
        r_q[r_head].valid  <= 1'b0;
        r_q[r_head].filled <= 1'b0;
        r_head             <= ptr_inc(r_head);
      end
      r_count    <= r_count + CntW'(w_push) - CntW'(w_pop);
      r_unfilled <= r_unfilled + CntW'(w_push) - CntW'(w_fill);
    end
  end

  // Pending mask: any valid entry targeting r; x0 never pends.
  always_comb begin
    w_pending = '0;
    for (int unsigned r = 1; r < NumRegs; r++) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (r_q[i].valid && (r_q[i].rd == 5'(r))) w_pending[r] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cve2_wb_arbiter.sv
// Register-file write-port arbiter: execute results take priority, completed
// loads drain from the queue otherwise. Drives decode stall and a sticky
// error for unexpected load responses.
module cve2_wb_arbiter
  import cve2_wb_pkg::*;
#(
  parameter bit          RV32E          = 1'b0,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned LoadQueueDepth = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  cve2_wb_arbiter_if.slave bus
);

  localparam int unsigned AddrW   = reg_addr_width(RV32E);
  localparam int unsigned NumRegs = 1 << AddrW;

  logic [4:0]           w_ex_addr, w_issue_rd, w_head_rd, w_waddr;
  logic [DataWidth-1:0] w_head_data, w_wdata;
  logic [NumRegs-1:0]   w_pending;
  logic                 w_head_ready, w_pop, w_we, w_resp_err;
  logic                 r_err;

  function automatic logic [4:0] trunc_addr(input logic [4:0] a);
    return 5'(a[AddrW-1:0]);
  endfunction

  assign w_ex_addr  = trunc_addr(bus.ex_waddr_i);
  assign w_issue_rd = trunc_addr(bus.lsu_issue_rd_i);

  cve2_wb_load_queue #(
    .DataWidth (DataWidth),
    .Depth     (LoadQueueDepth),
    .NumRegs   (NumRegs)
  ) u_queue (
    .i_clk        (clk_i),
    .i_rst        (rst_i),
    .i_issue      (bus.lsu_issue_i),
    .i_issue_rd   (w_issue_rd),
    .o_ready      (bus.lsu_issue_ready_o),
    .i_rvalid     (bus.lsu_rvalid_i),
    .i_rdata      (bus.lsu_rdata_i),
    .i_pop        (w_pop),
    .o_head_ready (w_head_ready),
    .o_head_rd    (w_head_rd),
    .o_head_data  (w_head_data),
    .o_pending    (w_pending),
    .o_resp_err   (w_resp_err)
  );

  // Write-port mux: execute wins, else drain a filled head; never write x0.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    w_pop   = 1'b0;
    if (bus.ex_we_i) begin
      w_we    = (w_ex_addr != '0);
      w_waddr = w_ex_addr;
      w_wdata = bus.ex_wdata_i;
    end else if (w_head_ready) begin
      w_we    = (w_head_rd != '0);
      w_waddr = w_head_rd;
      w_wdata = w_head_data;
      w_pop   = 1'b1;
    end
  end

  assign bus.rf_we_o    = w_we;
  assign bus.rf_waddr_o = w_waddr;
  assign bus.rf_wdata_o = w_wdata;

  assign bus.id_stall_o = bus.id_valid_i &
                          (w_pending[bus.id_raddr_a_i[AddrW-1:0]] |
                           w_pending[bus.id_raddr_b_i[AddrW-1:0]] |
                           w_pending[bus.id_waddr_i[AddrW-1:0]]);

  // Sticky flag for a load response arriving with nothing outstanding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_err <= 1'b0;
    else       r_err <= r_err | w_resp_err;
  end

  assign bus.err_o = r_err;

endmodule

// File: doc/cve2_wb_arbiter.md
# cve2_wb_arbiter

Writeback arbiter and load scoreboard that drives the single write port of the core's register file. It merges single-cycle execute results with out-of-order-in-time, in-order-returning load data. Late load data is held in a small queue and drained when the execute path leaves the write port idle. A pending-destination scoreboard drives the decode-stage stall for every register with an outstanding load.

## Interface
- RV32E, 0: 1 restricts register addresses to 4 bits (16 registers).
- DataWidth, 32: write data width.
- LoadQueueDepth, 2: maximum outstanding loads (issued and not yet written back); power of two, ≥1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- ex_we_i  in  1  execute result valid this cycle; always accepted
- ex_waddr_i  in  5  execute destination register
- ex_wdata_i  in  DataWidth  execute result
- lsu_issue_i  in  1  load issued this cycle; allocates a queue entry
- lsu_issue_rd_i  in  5  load destination register
- lsu_issue_ready_o  out  1  queue has a free entry
- lsu_rvalid_i  in  1  load data returning (in issue order)
- lsu_rdata_i  in  DataWidth  load data
- id_valid_i  in  1  decode holds a valid instruction
- id_raddr_a_i, id_raddr_b_i, id_waddr_i  in  5 each  decode source/destination registers
- id_stall_o  out  1  decode must stall (RAW/WAW on pending load)
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  register-file write address
- rf_wdata_o  out  DataWidth  register-file write data
- err_o  out  1  sticky: load response with no outstanding load

## Operation
- Queue entry: {valid, rd, data, filled}. Entries are circular with head, tail and fill pointers. The count is 0..LoadQueueDepth.
- Issue: `lsu_issue_i` and `lsu_issue_ready_o` together write {1, rd, -, 0} at tail. Issue while full is ignored; the entry is not allocated.
- Response: `lsu_rvalid_i` stores data into the oldest valid unfilled entry and sets filled. A response with no unfilled entry is dropped and sets `err_o`.
- Write port priority:
  - `ex_we_i` = 1: `rf_*` = ex inputs; queue does not drain.
  - otherwise, if the head entry is valid and filled: `rf_we_o` = (head.rd != 0), `rf_waddr_o` = head.rd, `rf_wdata_o` = head.data; the head pops this cycle.
  - otherwise `rf_we_o` = 0.
- Writes to x0 are never asserted. This applies to both sources.
- Register addresses are truncated to 4 bits when RV32E = 1.
- Scoreboard: pending[r] = OR over valid entries with rd == r; pending[0] is forced to 0.
- `id_stall_o` = `id_valid_i` & (pending[raddr_a] | pending[raddr_b] | pending[waddr]). A popping head still counts as pending in its drain cycle.
- `lsu_issue_ready_o` = (count < LoadQueueDepth). Same-cycle pop does not free a slot until the next cycle.
- Simultaneous issue, response and pop in one cycle are all legal. Pointers and count update independently, and count changes by issue − pop.

## Timing
- Reset values: `rf_we_o` = 0, `id_stall_o` = 0, `lsu_issue_ready_o` = 1, `err_o` = 0. Addresses and data are 0. The queue is empty and all pointers are 0.
- Reset asserted mid-operation discards all entries and any outstanding loads.
- Execute path: 0-cycle combinational pass-through to `rf_*`.
- Load path: a response in cycle N is written to the register file in cycle N+1 at the earliest, and later while `ex_we_i` holds the port.
- Stall releases in the cycle after the last matching entry pops.
- `rf_*` outputs are combinational from queue state and ex inputs. The register file samples them on its clock edge.

## Structure
- Package `cve2_wb_pkg` holds:
  - `wb_entry_t` struct
  - the register-address width function of RV32E
- Sub-module `cve2_wb_load_queue` holds the entry storage, the head/tail/fill pointers, count, ready and the pending mask.
- The top level holds the write-port mux, the stall logic and `err_o`.

## Test plan
- Reset, then ex_we=1, waddr=5, wdata=0xDEADBEEF: `rf_we_o`=1, addr 5, data 0xDEADBEEF in the same cycle. With waddr=0: `rf_we_o`=0.
- Issue a load to x7 in cycle 0, response 0x1234 in cycle 3, no ex traffic:
  - `id_stall_o` for raddr_a=7 holds in cycles 1–4.
  - `rf_we_o`=1 with addr 7, data 0x1234 in cycle 4.
  - stall clears in cycle 5.
- Load response in cycle N with `ex_we_i` held high for cycles N+1..N+3: the execute writes win, and the load writes in cycle N+4.
- Issue two loads (x3, x4) back-to-back:
  - `lsu_issue_ready_o`=0 after the second; a third issue is ignored.
  - Responses 0xA and 0xB write x3=0xA, then x4=0xB, in order.
- Response with an empty queue: `err_o`=1 and stays 1. No RF write occurs.
- Assert `rst_i` with two pending loads: queue is empty and stall=0 next cycle. A later response sets `err_o`.
